vend_credit_ctrl: RTL

//  Parametrised coin-credit vending controller; successor to the fixed 50/100 coin state machine.

---
 rtl/vend_credit_ctrl_if.sv | 29 ++
 rtl/vend_credit_ctrl.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/vend_credit_ctrl_if.sv
// Coin-front-end to vend-controller bundle: button levels in, status and pulses out.
// Latency: pure wiring, no state.
// Backpressure: none; the controller consumes button edges unconditionally.
interface vend_credit_ctrl_if #(
  parameter int CREDIT_W = 10
);
  logic                btn_a;
  logic                btn_b;
  logic                btn_c;
  logic                btn_cancel;
  logic [1:0]          state;
  logic [CREDIT_W-1:0] credit;
  logic                vend;
  logic [CREDIT_W-1:0] change;
  logic                change_vld;
  logic                reject;

  // Button/debounce side: drives levels, observes controller outputs.
  modport master (
    output btn_a, btn_b, btn_c, btn_cancel,
    input  state, credit, vend, change, change_vld, reject
  );

  // Controller side.
  modport slave (
    input  btn_a, btn_b, btn_c, btn_cancel,
    output state, credit, vend, change, change_vld, reject
  );
endinterface

// File: rtl/vend_credit_ctrl.sv
// Coin-credit vending controller: edge-detects coin/cancel buttons, accumulates credit, vends at PRICE.
// Latency: a button edge sampled at clock k is reflected on the registered outputs after edge k.
// Backpressure: none; coins that cannot be taken (over limit, lower priority, busy) pulse reject.
module vend_credit_ctrl #(
  parameter int CREDIT_W   = 10,
  parameter int COIN_A     = 50,
  parameter int COIN_B     = 100,
  parameter int COIN_C     = 500,
  parameter int PRICE      = 200,
  parameter int MAX_CREDIT = 600
) (
  input  logic              clk,
  input  logic              rst,
  vend_credit_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_COLLECT = 2'b01,
    S_VEND    = 2'b10,
    S_REFUND  = 2'b11
  } state_e;

  // Constants sized one bit wider than credit so the over-limit compare cannot wrap.
  localparam logic [CREDIT_W:0]   COIN_A_W = (CREDIT_W+1)'(COIN_A);
  localparam logic [CREDIT_W:0]   COIN_B_W = (CREDIT_W+1)'(COIN_B);
  localparam logic [CREDIT_W:0]   COIN_C_W = (CREDIT_W+1)'(COIN_C);
  localparam logic [CREDIT_W:0]   PRICE_W  = (CREDIT_W+1)'(PRICE);
  localparam logic [CREDIT_W:0]   MAX_W    = (CREDIT_W+1)'(MAX_CREDIT);
  localparam logic [CREDIT_W-1:0] PRICE_N  = CREDIT_W'(PRICE);

  // Edge-detect history.
  logic prev_a_q, prev_b_q, prev_c_q, prev_cancel_q;

  // Registered state and outputs with their next-state values.
  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                vend_q, vend_d;
  logic [CREDIT_W-1:0] change_q, change_d;
  logic                change_vld_q, change_vld_d;
  logic                reject_q, reject_d;

  // Per-cycle event decode.
  logic                trig_a, trig_b, trig_c, trig_cancel;
  logic                any_coin;
  logic                coin_hit;
  logic                coin_extra;
  logic [CREDIT_W:0]   coin_v;
  logic [CREDIT_W:0]   t_sum;
  logic [CREDIT_W-1:0] t_low;

  // Rising-edge triggers and priority selection of the single coin acted on (C > B > A).
  always_comb begin
    trig_a      = bus.btn_a      & ~prev_a_q;
    trig_b      = bus.btn_b      & ~prev_b_q;
    trig_c      = bus.btn_c      & ~prev_c_q;
    trig_cancel = bus.btn_cancel & ~prev_cancel_q;
    any_coin    = trig_a | trig_b | trig_c;

    coin_hit = any_coin;
    coin_v   = '0;
    if (trig_c) begin
      coin_v = COIN_C_W;
    end else if (trig_b) begin
      coin_v = COIN_B_W;
    end else if (trig_a) begin
      coin_v = COIN_A_W;
    end

    // Coins losing the priority race, including to a cancel, are refused.
    coin_extra = (trig_a & trig_b) | (trig_a & trig_c) | (trig_b & trig_c) |
                 (trig_cancel & any_coin);

    t_sum = {1'b0, credit_q} + coin_v;
    t_low = t_sum[CREDIT_W-1:0];
  end

  // Next-state and next-output decode; pulses default low so nothing is held two cycles.
  always_comb begin
    state_d      = state_q;
    credit_d     = credit_q;
    vend_d       = 1'b0;
    change_d     = '0;
    change_vld_d = 1'b0;
    reject_d     = 1'b0;

    case (state_q)
      S_IDLE, S_COLLECT: begin
        if (trig_cancel) begin
          reject_d = any_coin;
          // A cancel with nothing inserted has nothing to return.
          if (state_q == S_COLLECT) begin
            state_d      = S_REFUND;
            change_d     = credit_q;
            change_vld_d = 1'b1;
            credit_d     = '0;
          end
        end else if (coin_hit) begin
          reject_d = coin_extra;
          if (t_sum > MAX_W) begin
            reject_d = 1'b1;
          end else if (t_sum >= PRICE_W) begin
            state_d      = S_VEND;
            vend_d       = 1'b1;
            change_d     = t_low - PRICE_N;
            change_vld_d = 1'b1;
            credit_d     = '0;
          end else begin
            state_d  = S_COLLECT;
            credit_d = t_low;
          end
        end
      end
      // Dispense/refund cycles: single cycle, any coin arriving now is refused.
      default: begin
        state_d  = S_IDLE;
        credit_d = '0;
        reject_d = any_coin;
      end
    endcase
  end

  // State, output and edge-history registers; history reloads on reset so held buttons stay quiet.
  always_ff @(posedge clk) begin
    prev_a_q      <= bus.btn_a;
    prev_b_q      <= bus.btn_b;
    prev_c_q      <= bus.btn_c;
    prev_cancel_q <= bus.btn_cancel;
    if (rst) begin
      state_q      <= S_IDLE;
      credit_q     <= '0;
      vend_q       <= 1'b0;
      change_q     <= '0;
      change_vld_q <= 1'b0;
      reject_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      credit_q     <= credit_d;
      vend_q       <= vend_d;
      change_q     <= change_d;
      change_vld_q <= change_vld_d;
      reject_q     <= reject_d;
    end
  end

  assign bus.state      = state_q;
  assign bus.credit     = credit_q;
  assign bus.vend       = vend_q;
  assign bus.change     = change_q;
  assign bus.change_vld = change_vld_q;
  assign bus.reject     = reject_q;

endmodule
